// File: rtl/ct_mmu_sysmap_arb.sv
`default_nettype none
// ============================================================================
// Module      : ct_mmu_sysmap_arb
// Description : Round-robin arbiter that shares one combinational sysmap
//               attribute lookup among three MMU requesters
//               (0 = JTLB refill, 1 = PTW, 2 = LSU bypass/MMU-off).
//               The pipeline has three stages:
//                 stage 0 - arbitration, with a combinational grant;
//                 stage 1 - captures the winner's PA, which drives the lookup;
//                 stage 2 - registers the lookup flags and hit as the result.
//               It accepts one lookup per cycle and never stalls.
// Ports       : forever_cpuclk, cpurst_b (async, active-low)
//               rtu_yy_xx_flush          - kills in-flight lookups
//               reqN_sysmap_vld/pa       - requests (N = 0..2)
//               sysmap_arb_grnt          - one-hot combinational grant
//               mmu_sysmap_pa_y          - PA to the sysmap lookup
//               sysmap_mmu_flg_y/hit_y   - lookup return
//               sysmap_arb_rslt_vld/flg/hit - registered result
// Revision    : 1.0 - initial release
// ============================================================================
module ct_mmu_sysmap_arb #(
  parameter int REQ_NUM = 3,
  parameter int PA_W    = 28
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst_b,
  input  logic                rtu_yy_xx_flush,
  input  logic                req0_sysmap_vld,
  input  logic [PA_W-1:0]     req0_sysmap_pa,
  input  logic                req1_sysmap_vld,
  input  logic [PA_W-1:0]     req1_sysmap_pa,
  input  logic                req2_sysmap_vld,
  input  logic [PA_W-1:0]     req2_sysmap_pa,
  output logic [REQ_NUM-1:0]  sysmap_arb_grnt,
  output logic [PA_W-1:0]     mmu_sysmap_pa_y,
  input  logic [4:0]          sysmap_mmu_flg_y,
  input  logic [7:0]          sysmap_mmu_hit_y,
  output logic [REQ_NUM-1:0]  sysmap_arb_rslt_vld,
  output logic [4:0]          sysmap_arb_rslt_flg,
  output logic [7:0]          sysmap_arb_rslt_hit
);

  localparam logic [1:0] c_ptr_rst = 2'd0;

  // --------------------------------------------------------------------------
  // Stage 0: round-robin arbitration
  // --------------------------------------------------------------------------
  logic [2:0]      w_req_vld;
  logic [1:0]      w_win;
  logic            w_gnt_any;
  logic [1:0]      w_ptr_nxt;
  logic [PA_W-1:0] w_win_pa;

  logic [1:0]      r_ptr;
  logic            r_s1_vld;
  logic [1:0]      r_s1_id;
  logic [PA_W-1:0] r_s1_pa;
  logic            r_s2_vld;
  logic [1:0]      r_s2_id;
  logic [4:0]      r_s2_flg;
  logic [7:0]      r_s2_hit;

  assign w_req_vld = {req2_sysmap_vld, req1_sysmap_vld, req0_sysmap_vld};

  // The search starts at r_ptr and wraps through the other requesters in order.
  always_comb begin
    w_win = 2'd0;
    case (r_ptr)
      2'd1: begin
        if      (w_req_vld[1]) w_win = 2'd1;
        else if (w_req_vld[2]) w_win = 2'd2;
        else                   w_win = 2'd0;
      end
      2'd2: begin
        if      (w_req_vld[2]) w_win = 2'd2;
        else if (w_req_vld[0]) w_win = 2'd0;
        else                   w_win = 2'd1;
      end
      default: begin
        if      (w_req_vld[0]) w_win = 2'd0;
        else if (w_req_vld[1]) w_win = 2'd1;
        else                   w_win = 2'd2;
      end
    endcase
  end

  // The grant is gated by flush. It is also gated by reset, so that no grant
  // is visible while the core is held in reset.
  assign w_gnt_any       = (|w_req_vld) & ~rtu_yy_xx_flush & cpurst_b;
  assign sysmap_arb_grnt = w_gnt_any ? (3'b001 << w_win) : 3'b000;
  assign w_ptr_nxt       = (w_win == 2'd2) ? 2'd0 : (w_win + 2'd1);

  always_comb begin
    w_win_pa = req0_sysmap_pa;
    case (w_win)
      2'd1:    w_win_pa = req1_sysmap_pa;
      2'd2:    w_win_pa = req2_sysmap_pa;
      default: w_win_pa = req0_sysmap_pa;
    endcase
  end

  // --------------------------------------------------------------------------
  // Stage 1 capture and stage 2 result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_ptr    <= c_ptr_rst;
      r_s1_vld <= 1'b0;
      r_s1_id  <= 2'd0;
      r_s1_pa  <= '0;
      r_s2_vld <= 1'b0;
      r_s2_id  <= 2'd0;
      r_s2_flg <= 5'd0;
      r_s2_hit <= 8'd0;
    end else begin
      r_s1_vld <= w_gnt_any;
      // The PA holds when nothing is granted, which keeps the lookup inputs quiet.
      if (w_gnt_any) begin
        r_s1_id <= w_win;
        r_s1_pa <= w_win_pa;
        r_ptr   <= w_ptr_nxt;
      end

      if (r_s1_vld && !rtu_yy_xx_flush) begin
        r_s2_vld <= 1'b1;
        r_s2_id  <= r_s1_id;
        r_s2_flg <= sysmap_mmu_flg_y;
        r_s2_hit <= sysmap_mmu_hit_y;
      end else begin
        r_s2_vld <= 1'b0;
      end
    end
  end

  assign mmu_sysmap_pa_y = r_s1_pa;

  // A lookup that is already sitting in stage 2 during the flush cycle is also
  // killed. Without this gate, a lookup granted two cycles before the flush
  // would still deliver its result.
  assign sysmap_arb_rslt_vld = (r_s2_vld && !rtu_yy_xx_flush) ?
                               (3'b001 << r_s2_id) : 3'b000;
  assign sysmap_arb_rslt_flg = r_s2_flg;
  assign sysmap_arb_rslt_hit = r_s2_hit;

endmodule
`default_nettype wire

// File: tb/tb_ct_mmu_sysmap_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ct_mmu_sysmap_arb
// Description : Directed self-checking bench for ct_mmu_sysmap_arb. A small
//               behavioural sysmap model answers the lookup from
//               mmu_sysmap_pa_y:
//                 - PA[27] = 1 means a miss (hit 8'h00, flags 5'b01111);
//                 - otherwise PA[26:24] selects the region and
//                   flags = PA[8:4] ^ 5'h15.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ct_mmu_sysmap_arb;

  logic        clk;
  logic        cpurst_b;
  logic        flush;
  logic        req0_vld, req1_vld, req2_vld;
  logic [27:0] req0_pa, req1_pa, req2_pa;
  logic [2:0]  grnt;
  logic [27:0] pa_y;
  logic [4:0]  flg_y;
  logic [7:0]  hit_y;
  logic [2:0]  rslt_vld;
  logic [4:0]  rslt_flg;
  logic [7:0]  rslt_hit;

  int errors = 0;
  int checks = 0;

  function automatic logic [7:0] m_hit(input logic [27:0] pa);
    return pa[27] ? 8'h00 : (8'h01 << pa[26:24]);
  endfunction

  function automatic logic [4:0] m_flg(input logic [27:0] pa);
    return pa[27] ? 5'b01111 : (pa[8:4] ^ 5'h15);
  endfunction

  assign flg_y = m_flg(pa_y);
  assign hit_y = m_hit(pa_y);

  ct_mmu_sysmap_arb dut (
    .forever_cpuclk      (clk),
    .cpurst_b            (cpurst_b),
    .rtu_yy_xx_flush     (flush),
    .req0_sysmap_vld     (req0_vld),
    .req0_sysmap_pa      (req0_pa),
    .req1_sysmap_vld     (req1_vld),
    .req1_sysmap_pa      (req1_pa),
    .req2_sysmap_vld     (req2_vld),
    .req2_sysmap_pa      (req2_pa),
    .sysmap_arb_grnt     (grnt),
    .mmu_sysmap_pa_y     (pa_y),
    .sysmap_mmu_flg_y    (flg_y),
    .sysmap_mmu_hit_y    (hit_y),
    .sysmap_arb_rslt_vld (rslt_vld),
    .sysmap_arb_rslt_flg (rslt_flg),
    .sysmap_arb_rslt_hit (rslt_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cpurst_b = 1'b0; flush = 1'b0;
    req0_vld = 1'b1; req1_vld = 1'b1; req2_vld = 1'b1;
    req0_pa = 28'h0000010; req1_pa = 28'h0000020; req2_pa = 28'h0000030;
    cyc; cyc; #1;
    checks++; if (grnt !== 3'b000) begin errors++; $display("FAIL reset_grnt got=%b exp=000", grnt); end
    checks++; if (pa_y !== 28'h0) begin errors++; $display("FAIL reset_pa got=%h exp=0", pa_y); end
    checks++; if (rslt_vld !== 3'b000) begin errors++; $display("FAIL reset_rslt_vld got=%b exp=000", rslt_vld); end
    checks++; if (rslt_flg !== 5'd0 || rslt_hit !== 8'd0) begin errors++; $display("FAIL reset_rslt_data got=%h/%h exp=0/0", rslt_flg, rslt_hit); end
    req0_vld = 1'b0; req1_vld = 1'b0; req2_vld = 1'b0;
    cyc; cpurst_b = 1'b1;
  endtask

  task automatic test_single;
    cyc; req1_vld = 1'b1; req1_pa = 28'h0000800; #1;
    checks++; if (grnt !== 3'b010) begin errors++; $display("FAIL single_grnt got=%b exp=010", grnt); end
    cyc; req1_vld = 1'b0; #1;
    checks++; if (grnt !== 3'b000) begin errors++; $display("FAIL single_idle_grnt got=%b exp=000", grnt); end
    checks++; if (pa_y !== 28'h0000800) begin errors++; $display("FAIL single_pa got=%h exp=0000800", pa_y); end
    checks++; if (rslt_vld !== 3'b000) begin errors++; $display("FAIL single_early_vld got=%b exp=000", rslt_vld); end
    cyc; #1;
    checks++; if (rslt_vld !== 3'b010) begin errors++; $display("FAIL single_rslt_vld got=%b exp=010", rslt_vld); end
    checks++; if (rslt_flg !== m_flg(28'h0000800)) begin errors++; $display("FAIL single_flg got=%h exp=%h", rslt_flg, m_flg(28'h0000800)); end
    checks++; if (rslt_hit !== m_hit(28'h0000800)) begin errors++; $display("FAIL single_hit got=%h exp=%h", rslt_hit, m_hit(28'h0000800)); end
    cyc; #1;
    checks++; if (rslt_vld !== 3'b000) begin errors++; $display("FAIL single_pulse_len got=%b exp=000", rslt_vld); end
    checks++; if (rslt_flg !== m_flg(28'h0000800)) begin errors++; $display("FAIL single_flg_hold got=%h exp=%h", rslt_flg, m_flg(28'h0000800)); end
    // After granting requester 1 the pointer sits at 2, so requester 2 wins.
    cyc; req0_vld = 1'b1; req1_vld = 1'b1; req2_vld = 1'b1; #1;
    checks++; if (grnt !== 3'b100) begin errors++; $display("FAIL single_ptr_grnt got=%b exp=100", grnt); end
    cyc; req0_vld = 1'b0; req1_vld = 1'b0; req2_vld = 1'b0;
    cyc; cyc;
  endtask

  task automatic test_fairness;
    logic [27:0] pas [3];
    logic [2:0]  exp_g;
    logic [2:0]  exp_v;
    pas[0] = 28'h1000010; pas[1] = 28'h2000120; pas[2] = 28'h3000230;
    cpurst_b = 1'b0;
    cyc;
    cpurst_b = 1'b1;
    req0_pa = pas[0]; req1_pa = pas[1]; req2_pa = pas[2];
    for (int k = 0; k < 10; k++) begin
      if (k > 0) cyc;
      req0_vld = (k < 8); req1_vld = (k < 8); req2_vld = (k < 8);
      #1;
      exp_g = (k < 8) ? (3'b001 << (k % 3)) : 3'b000;
      checks++; if (grnt !== exp_g) begin errors++; $display("FAIL rr_grnt k=%0d got=%b exp=%b", k, grnt, exp_g); end
      if (k >= 2) begin
        exp_v = 3'b001 << ((k - 2) % 3);
        checks++; if (rslt_vld !== exp_v) begin errors++; $display("FAIL rr_rslt_vld k=%0d got=%b exp=%b", k, rslt_vld, exp_v); end
        checks++; if (rslt_flg !== m_flg(pas[(k-2)%3])) begin errors++; $display("FAIL rr_flg k=%0d got=%h exp=%h", k, rslt_flg, m_flg(pas[(k-2)%3])); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [27:0] bb [4];
    bb[0] = 28'h0000050; bb[1] = 28'h40001A0; bb[2] = 28'h5000FF0; bb[3] = 28'h7000330;
    for (int k = 0; k < 6; k++) begin
      cyc;
      req0_vld = (k < 4);
      if (k < 4) req0_pa = bb[k];
      #1;
      if (k < 4) begin
        checks++; if (grnt !== 3'b001) begin errors++; $display("FAIL b2b_grnt k=%0d got=%b exp=001", k, grnt); end
      end
      if (k >= 2) begin
        checks++; if (rslt_vld !== 3'b001) begin errors++; $display("FAIL b2b_rslt_vld k=%0d got=%b exp=001", k, rslt_vld); end
        checks++; if (rslt_flg !== m_flg(bb[k-2]) || rslt_hit !== m_hit(bb[k-2])) begin
          errors++; $display("FAIL b2b_data k=%0d got=%h/%h exp=%h/%h", k, rslt_flg, rslt_hit, m_flg(bb[k-2]), m_hit(bb[k-2]));
        end
      end
    end
    req0_vld = 1'b0;
  endtask

  task automatic test_flush;
    cyc; req0_vld = 1'b1; req0_pa = 28'h1000040; #1;
    checks++; if (grnt !== 3'b001) begin errors++; $display("FAIL flush_pre0_grnt got=%b exp=001", grnt); end
    cyc; req0_vld = 1'b0; req1_vld = 1'b1; req1_pa = 28'h2000080; #1;
    checks++; if (grnt !== 3'b010) begin errors++; $display("FAIL flush_pre1_grnt got=%b exp=010", grnt); end
    cyc; req1_vld = 1'b0; req2_vld = 1'b1; req2_pa = 28'h60005C0; flush = 1'b1; #1;
    checks++; if (grnt !== 3'b000) begin errors++; $display("FAIL flush_grnt got=%b exp=000", grnt); end
    checks++; if (rslt_vld !== 3'b000) begin errors++; $display("FAIL flush_rslt_t0 got=%b exp=000", rslt_vld); end
    cyc; flush = 1'b0; #1;
    checks++; if (grnt !== 3'b100) begin errors++; $display("FAIL flush_regrant got=%b exp=100", grnt); end
    checks++; if (rslt_vld !== 3'b000) begin errors++; $display("FAIL flush_rslt_t1 got=%b exp=000", rslt_vld); end
    cyc; req2_vld = 1'b0; #1;
    checks++; if (rslt_vld !== 3'b000) begin errors++; $display("FAIL flush_rslt_t2 got=%b exp=000", rslt_vld); end
    checks++; if (pa_y !== 28'h60005C0) begin errors++; $display("FAIL flush_pa got=%h exp=60005c0", pa_y); end
    cyc; #1;
    checks++; if (rslt_vld !== 3'b100) begin errors++; $display("FAIL flush_rslt_t3 got=%b exp=100", rslt_vld); end
    checks++; if (rslt_flg !== m_flg(28'h60005C0)) begin errors++; $display("FAIL flush_flg got=%h exp=%h", rslt_flg, m_flg(28'h60005C0)); end
  endtask

  task automatic test_miss;
    cyc; req0_vld = 1'b1; req0_pa = 28'hF000000;
    cyc; req0_vld = 1'b0;
    cyc; #1;
    checks++; if (rslt_vld !== 3'b001) begin errors++; $display("FAIL miss_vld got=%b exp=001", rslt_vld); end
    checks++; if (rslt_hit !== 8'h00) begin errors++; $display("FAIL miss_hit got=%h exp=00", rslt_hit); end
    checks++; if (rslt_flg !== 5'b01111) begin errors++; $display("FAIL miss_flg got=%b exp=01111", rslt_flg); end
  endtask

  task automatic test_reset_midflight;
    cyc; req2_vld = 1'b1; req2_pa = 28'h3000700; #1;
    checks++; if (grnt !== 3'b100) begin errors++; $display("FAIL rstmid_grnt got=%b exp=100", grnt); end
    cyc; req2_vld = 1'b0; cpurst_b = 1'b0;
    req0_vld = 1'b1; req1_vld = 1'b1; req2_vld = 1'b1; #1;
    checks++; if (grnt !== 3'b000) begin errors++; $display("FAIL rstmid_grnt_in_rst got=%b exp=000", grnt); end
    checks++; if (pa_y !== 28'h0) begin errors++; $display("FAIL rstmid_pa got=%h exp=0", pa_y); end
    checks++; if (rslt_vld !== 3'b000 || rslt_flg !== 5'd0 || rslt_hit !== 8'd0) begin
      errors++; $display("FAIL rstmid_rslt got=%b/%h/%h exp=000/0/0", rslt_vld, rslt_flg, rslt_hit);
    end
    cyc;
    req0_vld = 1'b0; req1_vld = 1'b0; req2_vld = 1'b0; cpurst_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc;
      #1;
      checks++; if (rslt_vld !== 3'b000) begin errors++; $display("FAIL rstmid_no_pulse k=%0d got=%b exp=000", k, rslt_vld); end
    end
    cyc; req0_vld = 1'b1; req1_vld = 1'b1; req2_vld = 1'b1; #1;
    checks++; if (grnt !== 3'b001) begin errors++; $display("FAIL rstmid_first_grnt got=%b exp=001", grnt); end
    cyc; req0_vld = 1'b0; req1_vld = 1'b0; req2_vld = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_back_to_back;
    test_flush;
    test_miss;
    test_reset_midflight;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
